// File: rtl/nios_multi_interval_timer_pkg.sv
// Shared definitions for the multi-channel interval timer: register offsets,
// CONTROL/STATUS bit positions and address-width helper.
package nios_multi_interval_timer_pkg;

   typedef enum logic [1:0] {
      REG_STATUS   = 2'd0,
      REG_CONTROL  = 2'd1,
      REG_PERIOD   = 2'd2,
      REG_SNAPSHOT = 2'd3
   } reg_off_e;

   localparam int CTRL_ITO    = 0;
   localparam int CTRL_CONT   = 1;
   localparam int CTRL_START  = 2;
   localparam int CTRL_STOP   = 3;
   localparam int CTRL_PRE_LO = 8;
   localparam int CTRL_PRE_HI = 15;

   localparam int STAT_TO   = 0;
   localparam int STAT_RUN  = 1;
   localparam int STAT_MISS = 2;

   // Channel-select width never drops below one bit, even for a single channel.
   function automatic int ch_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/nios_multi_interval_timer_channel.sv
// One timer channel: CONTROL/PERIOD/SNAPSHOT registers, prescaler,
// down-counter and TO/MISS flags, driven by pre-decoded write strobes.
module nios_multi_interval_timer_channel
   import nios_multi_interval_timer_pkg::*;
#(
   parameter int          CNT_W        = 32,
   parameter logic [31:0] RESET_PERIOD = 32'h7A11F
)
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        wr_status,
   input  logic        wr_control,
   input  logic        wr_period,
   input  logic        wr_snapshot,
   input  logic [31:0] writedata,
   output logic [31:0] rd_status,
   output logic [31:0] rd_control,
   output logic [31:0] rd_period,
   output logic [31:0] rd_snapshot,
   output logic        irq
);

   localparam logic [CNT_W-1:0] RST_CNT = RESET_PERIOD[CNT_W-1:0];
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic             ito, cont, run, to, miss;
   logic [7:0]       pre, presc;
   logic [CNT_W-1:0] period, counter, snapshot;
   logic             start, stop, halt, tick, timeout;
   logic             unused_wdata;

   // START beats STOP when both arrive in one write; a PERIOD write halts like STOP.
   assign start        = wr_control & writedata[CTRL_START];
   assign stop         = wr_control & writedata[CTRL_STOP] & ~writedata[CTRL_START];
   assign halt         = stop | wr_period;
   assign tick         = run & (presc == pre) & ~halt;
   assign timeout      = tick & (counter == '0);
   assign unused_wdata = ^writedata;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ito      <= 1'b0;
         cont     <= 1'b0;
         pre      <= '0;
         presc    <= '0;
         run      <= 1'b0;
         to       <= 1'b0;
         miss     <= 1'b0;
         period   <= RST_CNT;
         counter  <= RST_CNT;
         snapshot <= '0;
      end else begin
         if (wr_control) begin
            ito  <= writedata[CTRL_ITO];
            cont <= writedata[CTRL_CONT];
            pre  <= writedata[CTRL_PRE_HI:CTRL_PRE_LO];
         end

         if (halt)
            run <= 1'b0;
         else if (start)
            run <= 1'b1;
         else if (timeout & ~cont)
            run <= 1'b0;

         if (halt | start | ~run | (presc == pre))
            presc <= '0;
         else
            presc <= presc + 8'd1;

         if (wr_period) begin
            period  <= writedata[CNT_W-1:0];
            counter <= writedata[CNT_W-1:0];
         end else if (tick) begin
            counter <= (counter == '0) ? period : counter - CNT_ONE;
         end

         // A timeout outranks a STATUS clear; MISS only latches when no clear is pending.
         if (timeout) begin
            to <= 1'b1;
            if (!wr_status)
               miss <= miss | to;
         end else if (wr_status) begin
            to   <= 1'b0;
            miss <= 1'b0;
         end

         if (wr_snapshot)
            snapshot <= counter;
      end
   end

   always_comb begin
      rd_status                          = '0;
      rd_status[STAT_TO]                 = to;
      rd_status[STAT_RUN]                = run;
      rd_status[STAT_MISS]               = miss;
      rd_control                         = '0;
      rd_control[CTRL_ITO]               = ito;
      rd_control[CTRL_CONT]              = cont;
      rd_control[CTRL_PRE_HI:CTRL_PRE_LO] = pre;
      rd_period                          = '0;
      rd_period[CNT_W-1:0]               = period;
      rd_snapshot                        = '0;
      rd_snapshot[CNT_W-1:0]             = snapshot;
   end

   assign irq = to & ito;

endmodule

// File: rtl/nios_multi_interval_timer.sv
// Avalon-MM multi-channel interval timer: address decode, NUM_CH channel
// instances, registered read mux and interrupt reduction.
module nios_multi_interval_timer
   import nios_multi_interval_timer_pkg::*;
#(
   parameter int          NUM_CH       = 2,
   parameter int          CNT_W        = 32,
   parameter logic [31:0] RESET_PERIOD = 32'h7A11F,
   localparam int         CH_W         = ch_width(NUM_CH)
)
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic [CH_W+1:0]   address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic [NUM_CH-1:0] irq_vec,
   output logic              irq
);

   logic [CH_W-1:0] chan;
   reg_off_e        offset;
   logic            wr;
   logic [31:0]     rd_word [NUM_CH][4];
   logic [31:0]     rd_next;

   assign chan   = address[CH_W+1:2];
   assign offset = reg_off_e'(address[1:0]);
   assign wr     = chipselect & ~write_n;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic sel;
      assign sel = wr & (chan == CH_W'(c));

      nios_multi_interval_timer_channel #(
         .CNT_W        (CNT_W),
         .RESET_PERIOD (RESET_PERIOD)
      ) u_ch (
         .clk         (clk),
         .reset_n     (reset_n),
         .wr_status   (sel & (offset == REG_STATUS)),
         .wr_control  (sel & (offset == REG_CONTROL)),
         .wr_period   (sel & (offset == REG_PERIOD)),
         .wr_snapshot (sel & (offset == REG_SNAPSHOT)),
         .writedata   (writedata),
         .rd_status   (rd_word[c][0]),
         .rd_control  (rd_word[c][1]),
         .rd_period   (rd_word[c][2]),
         .rd_snapshot (rd_word[c][3]),
         .irq         (irq_vec[c])
      );
   end

   // Unpopulated channel slots fall through to zero.
   always_comb begin
      rd_next = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (chan == CH_W'(c))
            rd_next = rd_word[c][address[1:0]];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n)
         readdata <= '0;
      else
         readdata <= rd_next;
   end

   assign irq = |irq_vec;

endmodule

// File: tb/tb_nios_multi_interval_timer.sv
// Scoreboard bench for the multi-channel interval timer: a 2x32 instance for
// the main scenarios and a 3x16 instance for decode and width behaviour.
module tb_nios_multi_interval_timer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect, write_n;
   logic [31:0] writedata, readdata;
   logic [1:0]  irq_vec;
   logic        irq;
   logic [3:0]  address3;
   logic        chipselect3, write_n3;
   logic [31:0] writedata3, readdata3;
   logic [2:0]  irq_vec3;
   logic        irq3;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q [$];

   always #5 clk = ~clk;

   nios_multi_interval_timer #(.NUM_CH(2), .CNT_W(32), .RESET_PERIOD(32'h7A11F)) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata),
      .irq_vec(irq_vec), .irq(irq)
   );

   nios_multi_interval_timer #(.NUM_CH(3), .CNT_W(16), .RESET_PERIOD(32'h7A11F)) dut3 (
      .clk(clk), .reset_n(reset_n), .address(address3), .chipselect(chipselect3),
      .write_n(write_n3), .writedata(writedata3), .readdata(readdata3),
      .irq_vec(irq_vec3), .irq(irq3)
   );

   // Each bus operation occupies exactly one rising edge.
   task automatic bus_write(input bit sel, input logic [3:0] addr, input logic [31:0] data);
      @(negedge clk);
      if (sel) begin
         address3 = addr; writedata3 = data; chipselect3 = 1'b1; write_n3 = 1'b0;
      end else begin
         address = addr[2:0]; writedata = data; chipselect = 1'b1; write_n = 1'b0;
      end
      @(posedge clk);
      #1;
      chipselect = 1'b0; write_n = 1'b1; chipselect3 = 1'b0; write_n3 = 1'b1;
   endtask

   task automatic bus_read(input bit sel, input logic [3:0] addr, input logic [31:0] expected,
                           output logic [31:0] data);
      exp_q.push_back(expected);
      @(negedge clk);
      if (sel) begin
         address3 = addr; chipselect3 = 1'b1; write_n3 = 1'b1;
      end else begin
         address = addr[2:0]; chipselect = 1'b1; write_n = 1'b1;
      end
      @(posedge clk);
      #1;
      data = sel ? readdata3 : readdata;
      chipselect = 1'b0; chipselect3 = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] got, exp;
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (readdata !== 32'd0 || irq_vec !== 2'b00 || irq !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: readdata=%h irq_vec=%b irq=%b, want 0/00/0", readdata, irq_vec, irq);
      end
      checks++;
      if (readdata3 !== 32'd0 || irq_vec3 !== 3'b000) begin
         errors++;
         $display("[TB] FAIL reset_outputs3: readdata=%h irq_vec=%b, want 0/000", readdata3, irq_vec3);
      end
      reset_n = 1'b1;
      bus_read(0, 4'd2, 32'h0007A11F, got);
      exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("[TB] FAIL reset_period: got %h want %h", got, exp); end
      bus_read(0, 4'd0, 32'd0, got);
      exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("[TB] FAIL reset_status: got %h want %h", got, exp); end
      checks++;
      if (irq !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq: got %b want 0", irq); end
   endtask

   task automatic test_periodic();
      logic [31:0] got, exp;
      logic [2:0]  seq [9] = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd7};
      bus_write(0, 4'd2, 32'd3);
      bus_write(0, 4'd1, 32'h7);
      for (int i = 0; i < 9; i++) begin
         bus_read(0, 4'd0, {29'd0, seq[i]}, got);
         exp = exp_q.pop_front(); checks++;
         if (got !== exp) begin errors++; $display("[TB] FAIL periodic_status[%0d]: got %h want %h", i, got, exp); end
         if (i == 2 || i == 4) begin
            checks++;
            if (irq_vec !== ((i == 4) ? 2'b01 : 2'b00)) begin
               errors++;
               $display("[TB] FAIL periodic_irq[%0d]: got %b want %b", i, irq_vec, (i == 4) ? 2'b01 : 2'b00);
            end
         end
      end
      bus_write(0, 4'd0, 32'hFFFF_FFFF);
      bus_read(0, 4'd0, 32'd2, got);
      exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("[TB] FAIL periodic_clear: got %h want %h", got, exp); end
      bus_write(0, 4'd1, 32'h8);
      bus_read(0, 4'd0, 32'd0, got);
      exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("[TB] FAIL periodic_stop_on_tick: got %h want %h", got, exp); end
      bus_write(0, 4'd3, 32'd0);
      bus_read(0, 4'd3, 32'd0, got);
      exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("[TB] FAIL periodic_frozen_count: got %h want %h", got, exp); end
   endtask

   task automatic test_one_shot();
      logic [31:0] got, exp;
      bus_write(0, 4'd6, 32'd2);
      bus_write(0, 4'd5, 32'h0304);
      for (int i = 0; i < 16; i++) begin
         bus_read(0, 4'd4, (i < 12) ? 32'd2 : 32'd1, got);
         exp = exp_q.pop_front(); checks++;
         if (got !== exp) begin errors++; $display("[TB] FAIL oneshot_status[%0d]: got %h want %h", i, got, exp); end
      end
      checks++;
      if (irq_vec !== 2'b00) begin errors++; $display("[TB] FAIL oneshot_irq_masked: got %b want 00", irq_vec); end
      bus_read(0, 4'd5, 32'h0300, got);
      exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("[TB] FAIL oneshot_control: got %h want %h", got, exp); end
      bus_write(0, 4'd7, 32'd0);
      bus_read(0, 4'd7, 32'd2, got);
      exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("[TB] FAIL oneshot_reload: got %h want %h", got, exp); end
      bus_write(0, 4'd4, 32'd0);
      bus_read(0, 4'd4, 32'd0, got);
      exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("[TB] FAIL oneshot_clear: got %h want %h", got, exp); end
   endtask

   task automatic test_start_stop();
      logic [31:0] got, exp;
      bus_write(0, 4'd2, 32'd5);
      bus_write(0, 4'd1, 32'h000C);
      bus_read(0, 4'd0, 32'd2, got);
      exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("[TB] FAIL startstop_run: got %h want %h", got, exp); end
      bus_write(0, 4'd1, 32'h0008);
      bus_write(0, 4'd3, 32'd0);
      bus_read(0, 4'd3, 32'd4, got);
      exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("[TB] FAIL startstop_snapshot: got %h want %h", got, exp); end
      bus_read(0, 4'd0, 32'd0, got);
      exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("[TB] FAIL startstop_stopped: got %h want %h", got, exp); end
      bus_write(0, 4'd3, 32'd0);
      bus_read(0, 4'd3, 32'd4, got);
      exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("[TB] FAIL startstop_frozen: got %h want %h", got, exp); end
   endtask

   task automatic test_collisions();
      logic [31:0] got, exp;
      logic [2:0]  seq [3] = '{3'd2, 3'd2, 3'd3};
      bus_write(0, 4'd2, 32'd1);
      bus_write(0, 4'd1, 32'h7);
      for (int i = 0; i < 3; i++) begin
         bus_read(0, 4'd0, {29'd0, seq[i]}, got);
         exp = exp_q.pop_front(); checks++;
         if (got !== exp) begin errors++; $display("[TB] FAIL collide_status[%0d]: got %h want %h", i, got, exp); end
      end
      bus_write(0, 4'd0, 32'd0);
      bus_read(0, 4'd0, 32'd3, got);
      exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("[TB] FAIL collide_clear_vs_event: got %h want %h", got, exp); end
      bus_write(0, 4'd2, 32'd9);
      bus_read(0, 4'd0, 32'd1, got);
      exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("[TB] FAIL collide_period_stops: got %h want %h", got, exp); end
      bus_write(0, 4'd3, 32'd0);
      bus_read(0, 4'd3, 32'd9, got);
      exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("[TB] FAIL collide_period_load: got %h want %h", got, exp); end
      checks++;
      if (irq_vec !== 2'b01 || irq !== 1'b1) begin
         errors++; $display("[TB] FAIL collide_irq_on: irq_vec=%b irq=%b want 01/1", irq_vec, irq);
      end
      bus_write(0, 4'd1, 32'd0);
      checks++;
      if (irq_vec !== 2'b00 || irq !== 1'b0) begin
         errors++; $display("[TB] FAIL collide_irq_masked: irq_vec=%b irq=%b want 00/0", irq_vec, irq);
      end
      bus_read(0, 4'd0, 32'd1, got);
      exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("[TB] FAIL collide_to_kept: got %h want %h", got, exp); end
   endtask

   task automatic test_narrow();
      logic [31:0] got, exp;
      logic [3:0]  addr_tab [4] = '{4'd14, 4'd13, 4'd12, 4'd10};
      logic [31:0] exp_tab  [4] = '{32'd0, 32'd0, 32'd0, 32'h0000A11F};
      bus_read(1, 4'd2, 32'h0000A11F, got);
      exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("[TB] FAIL narrow_reset_period: got %h want %h", got, exp); end
      bus_write(1, 4'd14, 32'h1234);
      bus_write(1, 4'd13, 32'h7);
      for (int i = 0; i < 4; i++) begin
         bus_read(1, addr_tab[i], exp_tab[i], got);
         exp = exp_q.pop_front(); checks++;
         if (got !== exp) begin errors++; $display("[TB] FAIL narrow_ch3[%0d]: got %h want %h", i, got, exp); end
      end
      bus_read(1, 4'd8, 32'd0, got);
      exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("[TB] FAIL narrow_ch2_idle: got %h want %h", got, exp); end
      bus_write(1, 4'd10, 32'hABCD0003);
      bus_read(1, 4'd10, 32'd3, got);
      exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("[TB] FAIL narrow_truncate: got %h want %h", got, exp); end
      bus_write(1, 4'd9, 32'h6);
      for (int i = 0; i < 3; i++) begin
         bus_write(1, 4'd11, 32'd0);
         bus_read(1, 4'd11, (i == 1) ? 32'd1 : 32'd3, got);
         exp = exp_q.pop_front(); checks++;
         if (got !== exp) begin errors++; $display("[TB] FAIL narrow_wrap[%0d]: got %h want %h", i, got, exp); end
      end
      bus_read(1, 4'd8, 32'd3, got);
      exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("[TB] FAIL narrow_status: got %h want %h", got, exp); end
      checks++;
      if (irq_vec3 !== 3'b000 || irq3 !== 1'b0) begin
         errors++; $display("[TB] FAIL narrow_irq: irq_vec=%b irq=%b want 000/0", irq_vec3, irq3);
      end
   endtask

   initial begin
      reset_n = 1'b1;
      address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
      address3 = '0; chipselect3 = 1'b0; write_n3 = 1'b1; writedata3 = '0;
      test_reset();
      test_periodic();
      test_one_shot();
      test_start_stop();
      test_collisions();
      test_narrow();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
